// File: rtl/hazard_stall_ctrl.sv
// Hazard controller for the 5-stage MIPS pipeline: forwarding selects, load-use/branch stalls,
// control flushes and a multi-cycle mult/div freeze. Optional stall counters behind `STALL_CNT_EN.
module hazard_stall_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int MD_CYCLES  = 4,
  parameter int MD_CNT_W   = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] rs_d,
  input  logic [REG_ADDR_W-1:0] rt_d,
  input  logic [REG_ADDR_W-1:0] rs_e,
  input  logic [REG_ADDR_W-1:0] rt_e,
  input  logic [REG_ADDR_W-1:0] write_reg_e,
  input  logic [REG_ADDR_W-1:0] write_reg_m,
  input  logic [REG_ADDR_W-1:0] write_reg_w,
  input  logic                  reg_write_e,
  input  logic                  reg_write_m,
  input  logic                  reg_write_w,
  input  logic                  mem_to_reg_e,
  input  logic                  mem_to_reg_m,
  input  logic                  branch_d,
  input  logic                  jump_d,
  input  logic                  pc_src_d,
  input  logic                  md_start_e,
  output logic                  stall_f,
  output logic                  stall_d,
  output logic                  stall_e,
  output logic                  flush_d,
  output logic                  flush_e,
  output logic                  forward_a_d,
  output logic                  forward_b_d,
  output logic [1:0]            forward_a_e,
  output logic [1:0]            forward_b_e,
  output logic                  md_busy,
  output logic                  md_done
`ifdef STALL_CNT_EN
  ,
  output logic [31:0]           data_stall_cnt,
  output logic [31:0]           md_stall_cnt
`endif
);

  typedef enum logic {IDLE, BUSY} md_state_e;

  localparam logic [MD_CNT_W-1:0] MD_LOAD = MD_CNT_W'(MD_CYCLES - 1);
  localparam logic [MD_CNT_W-1:0] CNT_ONE = MD_CNT_W'(1);

  md_state_e           state_q;
  logic [MD_CNT_W-1:0] cnt_q;
  logic                md_busy_q;
  logic                md_done_q;

  logic lw_stall;
  logic br_stall;
  logic md_stall;
  logic data_stall;

  // $0 is hard-wired to zero, so a write to it is never a real producer.
  function automatic logic reg_hit(input logic [REG_ADDR_W-1:0] src,
                                   input logic [REG_ADDR_W-1:0] dst,
                                   input logic                  wr_en);
    return wr_en && (src != '0) && (src == dst);
  endfunction

  function automatic logic [1:0] fwd_sel_e(input logic [REG_ADDR_W-1:0] src);
    if (reg_hit(src, write_reg_m, reg_write_m))      return 2'b10;
    else if (reg_hit(src, write_reg_w, reg_write_w)) return 2'b01;
    else                                             return 2'b00;
  endfunction

  assign lw_stall = reg_hit(rs_d, write_reg_e, mem_to_reg_e) ||
                    reg_hit(rt_d, write_reg_e, mem_to_reg_e);

  assign br_stall = branch_d &&
                    (reg_hit(rs_d, write_reg_e, reg_write_e)  ||
                     reg_hit(rt_d, write_reg_e, reg_write_e)  ||
                     reg_hit(rs_d, write_reg_m, mem_to_reg_m) ||
                     reg_hit(rt_d, write_reg_m, mem_to_reg_m));

  // The done cycle (BUSY, cnt == 0) is deliberately not a stall, so the op costs exactly MD_CYCLES.
  assign md_stall = ((state_q == IDLE) && md_start_e) ||
                    ((state_q == BUSY) && (cnt_q != '0));

  assign data_stall = !md_stall && (lw_stall || br_stall);

  // NOTE: every combinational output defaults to 0 before any branch assigns it, which both
  // avoids latch inference and forces all outputs low while reset is held.
  always_comb begin
    stall_f     = 1'b0;
    stall_d     = 1'b0;
    stall_e     = 1'b0;
    flush_d     = 1'b0;
    flush_e     = 1'b0;
    forward_a_d = 1'b0;
    forward_b_d = 1'b0;
    forward_a_e = 2'b00;
    forward_b_e = 2'b00;
    md_busy     = 1'b0;
    md_done     = 1'b0;
    if (!reset) begin
      forward_a_d = reg_hit(rs_d, write_reg_m, reg_write_m);
      forward_b_d = reg_hit(rt_d, write_reg_m, reg_write_m);
      forward_a_e = fwd_sel_e(rs_e);
      forward_b_e = fwd_sel_e(rt_e);
      md_busy     = md_busy_q;
      md_done     = md_done_q;
      if (md_stall) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        stall_e = 1'b1;
      end else if (data_stall) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        flush_e = 1'b1;
      end else if (pc_src_d || jump_d) begin
        flush_d = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      md_busy_q <= 1'b0;
      md_done_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          md_done_q <= 1'b0;
          if (md_start_e) begin
            state_q   <= BUSY;
            cnt_q     <= MD_LOAD;
            md_busy_q <= 1'b1;
          end
        end
        BUSY: begin
          if (cnt_q != '0) begin
            cnt_q     <= cnt_q - CNT_ONE;
            md_done_q <= (cnt_q == CNT_ONE);
          end else begin
            // A request still asserted here belongs to the op just finished; it is not a restart.
            state_q   <= IDLE;
            md_busy_q <= 1'b0;
            md_done_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= IDLE;
          cnt_q     <= '0;
          md_busy_q <= 1'b0;
          md_done_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef STALL_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_stall_cnt <= '0;
      md_stall_cnt   <= '0;
    end else begin
      if (data_stall) data_stall_cnt <= data_stall_cnt + 32'd1;
      if (md_stall)   md_stall_cnt   <= md_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: directed steps then randomized cycles against
// a model that tracks mult/div progress as "cycles since the op was accepted".
module tb_hazard_stall_ctrl;

  localparam int MD_CYCLES = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] rs_d, rt_d, rs_e, rt_e, write_reg_e, write_reg_m, write_reg_w;
  logic       reg_write_e, reg_write_m, reg_write_w, mem_to_reg_e, mem_to_reg_m;
  logic       branch_d, jump_d, pc_src_d, md_start_e;
  logic       stall_f, stall_d, stall_e, flush_d, flush_e, forward_a_d, forward_b_d;
  logic [1:0] forward_a_e, forward_b_e;
  logic       md_busy, md_done;
`ifdef STALL_CNT_EN
  logic [31:0] data_stall_cnt, md_stall_cnt;
  logic [31:0] exp_data_cnt, exp_md_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int age = -1;  // cycles since the current mult/div op was accepted, -1 when none

  hazard_stall_ctrl #(.REG_ADDR_W(5), .MD_CYCLES(MD_CYCLES), .MD_CNT_W(3)) dut (
    .clk(clk), .reset(reset),
    .rs_d(rs_d), .rt_d(rt_d), .rs_e(rs_e), .rt_e(rt_e),
    .write_reg_e(write_reg_e), .write_reg_m(write_reg_m), .write_reg_w(write_reg_w),
    .reg_write_e(reg_write_e), .reg_write_m(reg_write_m), .reg_write_w(reg_write_w),
    .mem_to_reg_e(mem_to_reg_e), .mem_to_reg_m(mem_to_reg_m),
    .branch_d(branch_d), .jump_d(jump_d), .pc_src_d(pc_src_d), .md_start_e(md_start_e),
    .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e),
    .flush_d(flush_d), .flush_e(flush_e),
    .forward_a_d(forward_a_d), .forward_b_d(forward_b_d),
    .forward_a_e(forward_a_e), .forward_b_e(forward_b_e),
    .md_busy(md_busy), .md_done(md_done)
`ifdef STALL_CNT_EN
    , .data_stall_cnt(data_stall_cnt), .md_stall_cnt(md_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  logic [12:0] outs;
  assign outs = {stall_f, stall_d, stall_e, flush_d, flush_e, forward_a_d, forward_b_d,
                 forward_a_e, forward_b_e, md_busy, md_done};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic h(input logic [4:0] a, input logic [4:0] b, input logic en);
    return en && (a != 5'd0) && (a == b);
  endfunction

  function automatic int eff_age();
    return (age < 0 && md_start_e) ? 0 : age;
  endfunction

  function automatic logic [1:0] fe(input logic [4:0] src);
    if (h(src, write_reg_m, reg_write_m)) return 2'b10;
    if (h(src, write_reg_w, reg_write_w)) return 2'b01;
    return 2'b00;
  endfunction

  // Expected output vector, same bit order as outs.
  function automatic logic [12:0] ref_outs();
    logic [12:0] r;
    int e;
    logic md, data;
    r = '0;
    if (reset) return r;
    e = eff_age();
    md = (e >= 0) && (e < MD_CYCLES);
    data = (h(rs_d, write_reg_e, mem_to_reg_e) || h(rt_d, write_reg_e, mem_to_reg_e)) ||
           (branch_d && (h(rs_d, write_reg_e, reg_write_e) || h(rt_d, write_reg_e, reg_write_e) ||
                         h(rs_d, write_reg_m, mem_to_reg_m) || h(rt_d, write_reg_m, mem_to_reg_m)));
    r[7]   = h(rs_d, write_reg_m, reg_write_m);
    r[6]   = h(rt_d, write_reg_m, reg_write_m);
    r[5:4] = fe(rs_e);
    r[3:2] = fe(rt_e);
    r[1]   = (e >= 1);
    r[0]   = (e == MD_CYCLES);
    if (md)                      r[12:10] = 3'b111;
    else if (data)               begin r[12] = 1'b1; r[11] = 1'b1; r[8] = 1'b1; end
    else if (pc_src_d || jump_d) r[9] = 1'b1;
    return r;
  endfunction

  task automatic clr();
    {rs_d, rt_d, rs_e, rt_e, write_reg_e, write_reg_m, write_reg_w} = '0;
    {reg_write_e, reg_write_m, reg_write_w, mem_to_reg_e, mem_to_reg_m} = '0;
    {branch_d, jump_d, pc_src_d, md_start_e} = '0;
  endtask

  // Advance one clock edge and the model with it; returns 1 ns after the edge.
  task automatic tick();
    int e;
    logic [12:0] v;
    v = ref_outs();
    e = eff_age();
    @(posedge clk);
    if (reset) begin
      age = -1;
`ifdef STALL_CNT_EN
      exp_data_cnt = '0;
      exp_md_cnt   = '0;
`endif
    end else begin
`ifdef STALL_CNT_EN
      if (v[10])            exp_md_cnt   = exp_md_cnt + 32'd1;
      if (v[12] && !v[10])  exp_data_cnt = exp_data_cnt + 32'd1;
`endif
      age = (e < 0 || e == MD_CYCLES) ? -1 : e + 1;
    end
    #1;
  endtask

  task automatic sample(input string tag);
    @(negedge clk);
    check(tag, 32'(outs), 32'(ref_outs()));
  endtask

  initial begin
    clr();
    // Hazard-producing inputs while in reset: everything must still be 0.
    reset = 1'b1; md_start_e = 1'b1; mem_to_reg_e = 1'b1; write_reg_e = 5'd5; rt_d = 5'd5;
    #3;
    check("reset_outs", 32'(outs), 32'd0);
    tick();
    clr();
    reset = 1'b0;

    // E forwarding: M over W, then $0 never forwards.
    write_reg_m = 5'd3; reg_write_m = 1'b1; write_reg_w = 5'd3; reg_write_w = 1'b1; rs_e = 5'd3;
    sample("fwd_m_vec"); check("fwd_m", 32'(forward_a_e), 32'd2); tick();
    write_reg_m = 5'd4;
    sample("fwd_w_vec"); check("fwd_w", 32'(forward_a_e), 32'd1); tick();
    rs_e = 5'd0;
    sample("fwd_r0_vec"); check("fwd_r0", 32'(forward_a_e), 32'd0); tick();

    // Load-use stall, then released.
    clr();
    mem_to_reg_e = 1'b1; write_reg_e = 5'd5; rt_d = 5'd5;
    sample("lw_vec"); check("lw_ctl", 32'({stall_f, stall_d, flush_e, flush_d, stall_e}), 32'b11100); tick();
    mem_to_reg_e = 1'b0;
    sample("lw_off_vec"); check("lw_off", 32'({stall_f, stall_d, flush_e, flush_d}), 32'd0); tick();

    // Branch hazard on an ALU result in E, then forwarded from M.
    clr();
    branch_d = 1'b1; reg_write_e = 1'b1; write_reg_e = 5'd8; rs_d = 5'd8;
    sample("br_vec"); check("br_stall", 32'({stall_d, flush_e}), 32'b11); tick();
    reg_write_e = 1'b0; write_reg_e = 5'd0; write_reg_m = 5'd8; reg_write_m = 1'b1;
    sample("br_fwd_vec"); check("br_fwd", 32'({stall_d, forward_a_d}), 32'b01); tick();

    // Taken branch flush, then overridden by a load-use stall.
    clr();
    pc_src_d = 1'b1;
    sample("flush_vec"); check("flush", 32'({flush_d, stall_d}), 32'b10); tick();
    mem_to_reg_e = 1'b1; write_reg_e = 5'd9; rs_d = 5'd9;
    sample("flush_lw_vec"); check("flush_lw", 32'({flush_d, stall_d}), 32'b01); tick();

    // Mult/div: request held through the done cycle, dropped afterwards.
    clr();
    md_start_e = 1'b1;
    for (int c = 0; c <= MD_CYCLES; c++) begin
      sample($sformatf("md_c%0d_vec", c));
      check($sformatf("md_c%0d", c), 32'({stall_f, stall_d, stall_e, md_busy, md_done}),
            32'({{3{c < MD_CYCLES}}, c >= 1, c == MD_CYCLES}));
      tick();
    end
    md_start_e = 1'b0;
    sample("md_idle_vec"); check("md_idle", 32'({stall_e, md_busy, md_done}), 32'd0); tick();

    // Reset during an op: outputs drop immediately, FSM comes back idle.
    md_start_e = 1'b1;
    tick(); tick();
    branch_d = 1'b1; reg_write_e = 1'b1; write_reg_e = 5'd7; rs_d = 5'd7;
    reg_write_m = 1'b1; write_reg_m = 5'd2; rs_e = 5'd2;
    reset = 1'b1;
    #1;
    check("mid_reset", 32'(outs), 32'd0);
    tick();
    reset = 1'b0;
    clr();
    sample("post_reset_vec"); check("post_reset", 32'({stall_f, stall_e, md_busy}), 32'd0); tick();

    // Randomized traffic; small register range keeps collisions frequent.
    for (int i = 0; i < 400; i++) begin
      {rs_d, rt_d, rs_e, rt_e} = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      {write_reg_e, write_reg_m, write_reg_w} = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                                                 5'($urandom_range(0, 7))};
      {reg_write_e, reg_write_m, reg_write_w, mem_to_reg_e, mem_to_reg_m} = 5'($urandom);
      {branch_d, jump_d, pc_src_d} = 3'($urandom);
      md_start_e = (age >= 0) ? 1'b1 : ($urandom_range(0, 7) == 0);
      sample($sformatf("rnd%0d", i));
      check("rnd_inv", 32'(stall_d & flush_d), 32'd0);
      tick();
    end

`ifdef STALL_CNT_EN
    check("data_cnt", data_stall_cnt, exp_data_cnt);
    check("md_cnt", md_stall_cnt, exp_md_cnt);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
